// File: rtl/vpu_wb_pack_unit_pkg.sv
// Shared types, default widths and address helpers for the VPU write-back pack unit.
// Bank-interleaved addressing: the low BANK_LG2 bits of a flat line address select the bank.
package vpu_wb_pack_unit_pkg;

  localparam int WB_OPERAND_WIDTH = 8;
  localparam int WB_VLANE_CNT     = 8;
  localparam int WB_EXEC_CNT      = 4;
  localparam int WB_BEAT_W        = WB_OPERAND_WIDTH * WB_VLANE_CNT;
  localparam int WB_LINE_W        = WB_BEAT_W * WB_EXEC_CNT;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RUN,
    WB_DRAIN_ABORT,
    WB_DONE
  } wb_state_e;

  function automatic logic [31:0] get_bank_id(input logic [31:0] flat, input int unsigned bank_lg2);
    return flat & ((32'd1 << bank_lg2) - 32'd1);
  endfunction

  function automatic logic [31:0] get_waddr(input logic [31:0] flat, input int unsigned bank_lg2);
    return flat >> bank_lg2;
  endfunction

endpackage

// File: rtl/vpu_wb_line_buf.sv
// Two-entry ping-pong line buffer: beats fill one entry while the other waits for the SRAM port.
// Entries are filled and drained strictly in order, so the read pointer always names the oldest full line.
module vpu_wb_line_buf #(
  parameter int BEAT_W   = 64,
  parameter int EXEC_CNT = 4,
  localparam int LINE_W  = BEAT_W * EXEC_CNT,
  localparam int PTR_W   = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              free,
  output logic              line_done,
  output logic              both_full,
  output logic              rd_full,
  output logic              alt_full,
  output logic [LINE_W-1:0] rd_data,
  output logic [LINE_W-1:0] alt_data
);

  logic [1:0]                       full_q;
  logic                             fill_q;
  logic                             rd_q;
  logic [PTR_W-1:0]                 beat_q;
  logic [EXEC_CNT-1:0][BEAT_W-1:0]  line_q [2];

  assign line_done = wr_en && (beat_q == PTR_W'(EXEC_CNT - 1));
  assign both_full = &full_q;
  assign rd_full   = full_q[rd_q];
  assign alt_full  = full_q[~rd_q];
  assign rd_data   = line_q[rd_q];
  assign alt_data  = line_q[~rd_q];

  // The completing entry is always the empty fill entry, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      full_q <= 2'b00;
      fill_q <= 1'b0;
      rd_q   <= 1'b0;
      beat_q <= '0;
    end else begin
      if (wr_en) begin
        if (line_done) begin
          beat_q <= '0;
          fill_q <= ~fill_q;
        end else begin
          beat_q <= beat_q + PTR_W'(1);
        end
      end
      if (free) begin
        full_q[rd_q] <= 1'b0;
        rd_q         <= ~rd_q;
      end
      if (line_done) full_q[fill_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_q[fill_q][beat_q] <= wr_data;
  end

endmodule

// File: rtl/vpu_wb_pack_unit.sv
// Packs lane beats into SRAM lines and writes a multi-line burst to bank-interleaved SRAM.
// Write fields are registered and held until ack; a second full line issues back-to-back on ack.
module vpu_wb_pack_unit
  import vpu_wb_pack_unit_pkg::*;
#(
  parameter int OPERAND_WIDTH   = WB_OPERAND_WIDTH,
  parameter int VLANE_CNT       = WB_VLANE_CNT,
  parameter int EXEC_CNT        = WB_EXEC_CNT,
  parameter int SRAM_BANK_CNT   = 4,
  parameter int SRAM_BANK_DEPTH = 256,
  parameter int MAX_LINES       = 16,
  localparam int BEAT_W    = OPERAND_WIDTH * VLANE_CNT,
  localparam int LINE_W    = BEAT_W * EXEC_CNT,
  localparam int BANK_LG2  = $clog2(SRAM_BANK_CNT),
  localparam int DEPTH_LG2 = $clog2(SRAM_BANK_DEPTH),
  localparam int FLAT_W    = BANK_LG2 + DEPTH_LG2,
  localparam int CNT_W     = $clog2(MAX_LINES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reset_cmd_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [FLAT_W-1:0]    req_waddr_i,
  input  logic [CNT_W-1:0]     req_lines_i,
  input  logic                 wb_data_valid_i,
  output logic                 wb_data_ready_o,
  input  logic [BEAT_W-1:0]    wb_data_i,
  output logic                 w_req_o,
  input  logic                 w_ack_i,
  output logic [BANK_LG2-1:0]  w_wid_o,
  output logic [DEPTH_LG2-1:0] w_addr_o,
  output logic                 w_web_o,
  output logic                 w_wlast_o,
  output logic [LINE_W-1:0]    w_wdata_o,
  output logic                 wb_done_o,
  output logic                 busy_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wb_state_e             state_q, state_nxt;
  logic [FLAT_W-1:0]     waddr_q;
  logic [CNT_W-1:0]      lines_q, lines_packed_q, lines_written_q;
  logic                  w_req_q, w_web_q, w_wlast_q;
  logic [BANK_LG2-1:0]   w_wid_q;
  logic [DEPTH_LG2-1:0]  w_addr_q;
  logic [LINE_W-1:0]     w_wdata_q;

  logic                  run, ack_fire, beat_fire, issue_new, issue_b2b;
  logic                  line_done, both_full, rd_full, alt_full, buf_clear, buf_free;
  logic [LINE_W-1:0]     rd_data, alt_data;
  logic [CNT_W-1:0]      issue_idx;
  logic [FLAT_W-1:0]     issue_flat;
  logic                  issue_last;

  assign run       = (state_q == WB_RUN);
  assign ack_fire  = w_req_q && w_ack_i;
  assign beat_fire = wb_data_valid_i && wb_data_ready_o;
  assign issue_new = run && !reset_cmd_i && !w_req_q && rd_full;
  assign issue_b2b = run && !reset_cmd_i && ack_fire && alt_full;
  assign buf_free  = run && ack_fire;
  assign buf_clear = !run || reset_cmd_i;

  assign req_ready_o     = (state_q == WB_IDLE);
  assign busy_o          = (state_q != WB_IDLE);
  assign wb_done_o       = (state_q == WB_DONE);
  assign wb_data_ready_o = run && !both_full && (lines_packed_q < lines_q);

  assign w_req_o   = w_req_q;
  assign w_web_o   = w_web_q;
  assign w_wlast_o = w_wlast_q;
  assign w_wid_o   = w_wid_q;
  assign w_addr_o  = w_addr_q;
  assign w_wdata_o = w_wdata_q;

  vpu_wb_line_buf #(
    .BEAT_W   (BEAT_W),
    .EXEC_CNT (EXEC_CNT)
  ) u_line_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (buf_clear),
    .wr_en     (beat_fire),
    .wr_data   (wb_data_i),
    .free      (buf_free),
    .line_done (line_done),
    .both_full (both_full),
    .rd_full   (rd_full),
    .alt_full  (alt_full),
    .rd_data   (rd_data),
    .alt_data  (alt_data)
  );

  // A back-to-back issue targets the line after the one being acked this cycle.
  always_comb begin
    issue_idx  = issue_b2b ? (lines_written_q + CNT_ONE) : lines_written_q;
    issue_flat = waddr_q + FLAT_W'(issue_idx);
    issue_last = ((issue_idx + CNT_ONE) == lines_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WB_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      WB_IDLE: begin
        if (req_valid_i) state_nxt = (req_lines_i == '0) ? WB_DONE : WB_RUN;
      end
      WB_RUN: begin
        if (reset_cmd_i)
          state_nxt = (w_req_q && !w_ack_i) ? WB_DRAIN_ABORT : WB_IDLE;
        else if (ack_fire && ((lines_written_q + CNT_ONE) == lines_q))
          state_nxt = WB_DONE;
      end
      WB_DRAIN_ABORT: begin
        if (w_ack_i) state_nxt = WB_IDLE;
      end
      WB_DONE: begin
        if (reset_cmd_i) state_nxt = WB_IDLE;
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waddr_q         <= '0;
      lines_q         <= '0;
      lines_packed_q  <= '0;
      lines_written_q <= '0;
      w_req_q         <= 1'b0;
      w_web_q         <= 1'b1;
      w_wlast_q       <= 1'b0;
      w_wid_q         <= '0;
      w_addr_q        <= '0;
      w_wdata_q       <= '0;
    end else begin
      if ((state_q == WB_IDLE) && req_valid_i) begin
        waddr_q         <= req_waddr_i;
        lines_q         <= req_lines_i;
        lines_packed_q  <= '0;
        lines_written_q <= '0;
      end
      if (run && line_done) lines_packed_q  <= lines_packed_q + CNT_ONE;
      if (buf_free)         lines_written_q <= lines_written_q + CNT_ONE;
      if (issue_new || issue_b2b) begin
        w_req_q   <= 1'b1;
        w_web_q   <= 1'b0;
        w_wlast_q <= issue_last;
        w_wid_q   <= BANK_LG2'(get_bank_id(32'(issue_flat), BANK_LG2));
        w_addr_q  <= DEPTH_LG2'(get_waddr(32'(issue_flat), BANK_LG2));
        w_wdata_q <= issue_b2b ? alt_data : rd_data;
      end else if (ack_fire) begin
        w_req_q   <= 1'b0;
        w_web_q   <= 1'b1;
        w_wlast_q <= 1'b0;
      end
    end
  end

endmodule
